// File: rtl/vga_pkg.sv
// Shared VGA raster types, default 640x480@60 timing and the segment end-count helper.
package vga_pkg;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} vga_phase_t;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Last count value of each segment; the axis leaves that segment on the following edge.
    typedef struct packed {
        logic [CNT_W-1:0] active_end;
        logic [CNT_W-1:0] front_end;
        logic [CNT_W-1:0] sync_end;
        logic [CNT_W-1:0] total_end;
    } seg_ends_t;

    function automatic seg_ends_t seg_ends(input int active, input int fp, input int sync, input int bp);
        seg_ends_t e;
        e.active_end = CNT_W'(active - 1);
        e.front_end  = CNT_W'(active + fp - 1);
        e.sync_end   = CNT_W'(active + fp + sync - 1);
        e.total_end  = CNT_W'(active + fp + sync + bp - 1);
        return e;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase, stepping when advance is high.
module vga_axis_counter import vga_pkg::*; #(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic             clk_25,
    input  logic             rst_n,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output vga_phase_t       phase,
    output logic             wrap,
    output logic             sync
);

    localparam seg_ends_t ENDS = seg_ends(ACTIVE, FP, SYNC, BP);

    logic [CNT_W-1:0] count_d, count_q;
    vga_phase_t       phase_d, phase_q;

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (advance) begin
            if (count_q == ENDS.total_end) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
            case (phase_q)
                PH_ACTIVE: if (count_q == ENDS.active_end) phase_d = PH_FRONT;
                PH_FRONT:  if (count_q == ENDS.front_end)  phase_d = PH_SYNC;
                PH_SYNC:   if (count_q == ENDS.sync_end)   phase_d = PH_BACK;
                PH_BACK:   if (count_q == ENDS.total_end)  phase_d = PH_ACTIVE;
                default:   phase_d = PH_BACK;
            endcase
        end
    end

    // Reset parks the axis on its last position so the first live edge lands on 0 / PH_ACTIVE.
    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            count_q <= ENDS.total_end;
            phase_q <= PH_BACK;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count = count_q;
    assign phase = phase_q;
    assign wrap  = advance && (count_q == ENDS.total_end);
    assign sync  = (phase_q == PH_SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing from the 25 MHz pixel clock.
// Define VGA_TESTPAT_EN to add the registered 4-bit vertical-bar test pattern port test_pix.
module vga_timing_gen import vga_pkg::*; #(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk_25,
    input  logic             rst_n,
    output logic             hsync,
    output logic             vsync,
    output logic             disp_active,
    output logic             line_end,
    output logic             frame_end,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count
`ifdef VGA_TESTPAT_EN
    ,
    output logic [3:0]       test_pix
`endif
);

    localparam logic [CNT_W-1:0] H_LAST_ACTIVE = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST_ACTIVE = CNT_W'(V_ACTIVE - 1);

    vga_phase_t h_phase, v_phase;
    logic       h_wrap, v_wrap;
    logic       h_in_sync, v_in_sync;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .clk_25  (clk_25),
        .rst_n   (rst_n),
        .advance (1'b1),
        .count   (h_count),
        .phase   (h_phase),
        .wrap    (h_wrap),
        .sync    (h_in_sync)
    );

    // The vertical axis steps only on the last pixel of each line, so vsync moves on the h wrap edge.
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .clk_25  (clk_25),
        .rst_n   (rst_n),
        .advance (h_wrap),
        .count   (v_count),
        .phase   (v_phase),
        .wrap    (v_wrap),
        .sync    (v_in_sync)
    );

    assign hsync       = h_in_sync ? SYNC_POL : ~SYNC_POL;
    assign vsync       = v_in_sync ? SYNC_POL : ~SYNC_POL;
    assign disp_active = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    assign line_end    = (h_count == H_LAST_ACTIVE) && (v_phase == PH_ACTIVE);
    assign frame_end   = (h_count == H_LAST_ACTIVE) && (v_count == V_LAST_ACTIVE);

`ifdef VGA_TESTPAT_EN
    logic [CNT_W-1:0] h_next, v_next;
    logic [3:0]       test_pix_d, test_pix_q;

    // Pattern is computed for the pixel the counters move to, so it lands in the same cycle.
    always_comb begin
        h_next = h_wrap ? '0 : h_count + CNT_W'(1);
        v_next = v_count;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v_count + CNT_W'(1);
        end
        test_pix_d = 4'd0;
        if ((h_next < CNT_W'(H_ACTIVE)) && (v_next < CNT_W'(V_ACTIVE))) begin
            test_pix_d = h_next[9:6];
        end
    end

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            test_pix_q <= 4'd0;
        end else begin
            test_pix_q <= test_pix_d;
        end
    end

    assign test_pix = test_pix_q;
`else
    logic v_wrap_unused;
    assign v_wrap_unused = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line timing, reduced-size instance for frame-level checks.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp;
    } tim_t;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       da;
        logic       le;
        logic       fe;
        logic [3:0] tp;
    } obs_t;

    typedef struct {
        int   steps;
        obs_t e;
    } vec_t;

    tim_t t_def = '{640, 16, 96, 48, 480, 10, 2, 33};
    tim_t t_s   = '{40, 4, 8, 4, 30, 3, 2, 5};
    int   frame_def = 800 * 525;
    int   frame_s   = 56 * 40;

    logic       clk_25;
    logic       rst_n, rst_s_n;
    logic       hsync, vsync, disp_active, line_end, frame_end;
    logic [9:0] h_count, v_count;
    logic       hsync_s, vsync_s, disp_active_s, line_end_s, frame_end_s;
    logic [9:0] h_count_s, v_count_s;
`ifdef VGA_TESTPAT_EN
    logic [3:0] test_pix, test_pix_s;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int pos_def  = 0;
    int pos_s    = 0;
    logic [9:0] exp_q[$];

    vga_timing_gen dut (
        .clk_25      (clk_25),
        .rst_n       (rst_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .disp_active (disp_active),
        .line_end    (line_end),
        .frame_end   (frame_end),
        .h_count     (h_count),
        .v_count     (v_count)
`ifdef VGA_TESTPAT_EN
        ,
        .test_pix    (test_pix)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(5), .SYNC_POL(1'b0)
    ) dut_s (
        .clk_25      (clk_25),
        .rst_n       (rst_s_n),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .disp_active (disp_active_s),
        .line_end    (line_end_s),
        .frame_end   (frame_end_s),
        .h_count     (h_count_s),
        .v_count     (v_count_s)
`ifdef VGA_TESTPAT_EN
        ,
        .test_pix    (test_pix_s)
`endif
    );

    // ---------------- clock ----------------
    initial clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    // ---------------- reference model ----------------
    // Reset state equals the last pixel of the frame, so a reset simply parks pos there.
    function automatic obs_t model(input tim_t t, input int pos);
        obs_t o;
        int ht, h, v;
        ht = t.ha + t.hfp + t.hs + t.hbp;
        h = pos % ht;
        v = pos / ht;
        o.h  = 10'(h);
        o.v  = 10'(v);
        o.hs = !((h >= t.ha + t.hfp) && (h < t.ha + t.hfp + t.hs));
        o.vs = !((v >= t.va + t.vfp) && (v < t.va + t.vfp + t.vs));
        o.da = (h < t.ha) && (v < t.va);
        o.le = (h == t.ha - 1) && (v < t.va);
        o.fe = (h == t.ha - 1) && (v == t.va - 1);
        o.tp = 4'd0;
`ifdef VGA_TESTPAT_EN
        if (o.da) o.tp = 4'(h / 64);
`endif
        return o;
    endfunction

    function automatic obs_t sample_def();
        obs_t o;
        o = '{h: h_count, v: v_count, hs: hsync, vs: vsync, da: disp_active,
              le: line_end, fe: frame_end, tp: 4'd0};
`ifdef VGA_TESTPAT_EN
        o.tp = test_pix;
`endif
        return o;
    endfunction

    function automatic obs_t sample_s();
        obs_t o;
        o = '{h: h_count_s, v: v_count_s, hs: hsync_s, vs: vsync_s, da: disp_active_s,
              le: line_end_s, fe: frame_end_s, tp: 4'd0};
`ifdef VGA_TESTPAT_EN
        o.tp = test_pix_s;
`endif
        return o;
    endfunction

    function automatic vec_t mk(input int s, input int h, input int v, input logic hs, input logic vs,
                                input logic da, input logic le, input logic fe, input int tp);
        vec_t r;
        r.steps = s;
        r.e = '{h: 10'(h), v: 10'(v), hs: hs, vs: vs, da: da, le: le, fe: fe, tp: 4'(tp)};
`ifndef VGA_TESTPAT_EN
        r.e.tp = 4'd0;
`endif
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b da=%b le=%b fe=%b tp=%0d, want h=%0d v=%0d hs=%b vs=%b da=%b le=%b fe=%b tp=%0d",
                     name, act.h, act.v, act.hs, act.vs, act.da, act.le, act.fe, act.tp,
                     exp.h, exp.v, exp.hs, exp.vs, exp.da, exp.le, exp.fe, exp.tp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    // ---------------- drivers ----------------
    task automatic tick_def(input logic r);
        rst_n = r;
        @(posedge clk_25);
        pos_def = r ? (pos_def + 1) % frame_def : frame_def - 1;
        #1;
    endtask

    task automatic tick_s(input logic r);
        rst_s_n = r;
        @(posedge clk_25);
        pos_s = r ? (pos_s + 1) % frame_s : frame_s - 1;
        #1;
    endtask

    task automatic run_frames_s(input string tag);
        int le_cnt, fe_cnt, fe_alone, vs_low, hs_low, da_cnt, vs_first_h, vs_first_v, step;
        int fe_step[$];
        logic [9:0] want_v;
        le_cnt = 0; fe_cnt = 0; fe_alone = 0; vs_low = 0; hs_low = 0; da_cnt = 0;
        vs_first_h = -1; vs_first_v = -1; step = 0;
        exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 30; i++) exp_q.push_back(10'(i));
        end
        repeat (2 * frame_s) begin
            tick_s(1'b1);
            step++;
            check_obs({tag, "_model"}, sample_s(), model(t_s, pos_s));
            if (disp_active_s) da_cnt++;
            if (!hsync_s) hs_low++;
            if (!vsync_s) begin
                if (vs_low == 0) begin
                    vs_first_h = int'(h_count_s);
                    vs_first_v = int'(v_count_s);
                end
                vs_low++;
            end
            if (line_end_s) begin
                le_cnt++;
                if (exp_q.size() == 0) begin
                    check_int({tag, "_line_end_extra"}, int'(v_count_s), -1);
                end else begin
                    want_v = exp_q.pop_front();
                    check_int({tag, "_line_end_row"}, int'(v_count_s), int'(want_v));
                end
            end
            if (frame_end_s) begin
                fe_cnt++;
                fe_step.push_back(step);
                if (!line_end_s) fe_alone++;
                check_int({tag, "_frame_end_h"}, int'(h_count_s), 39);
                check_int({tag, "_frame_end_v"}, int'(v_count_s), 29);
            end
        end
        check_int({tag, "_line_end_count"}, le_cnt, 60);
        check_int({tag, "_line_end_left"}, exp_q.size(), 0);
        check_int({tag, "_frame_end_count"}, fe_cnt, 2);
        check_int({tag, "_frame_end_without_line_end"}, fe_alone, 0);
        check_int({tag, "_frame_period"}, (fe_step.size() == 2) ? fe_step[1] - fe_step[0] : -1, 2240);
        check_int({tag, "_vsync_low_clocks"}, vs_low, 2 * 2 * 56);
        check_int({tag, "_vsync_start_h"}, vs_first_h, 0);
        check_int({tag, "_vsync_start_v"}, vs_first_v, 33);
        check_int({tag, "_hsync_low_clocks"}, hs_low, 2 * 40 * 8);
        check_int({tag, "_disp_clocks"}, da_cnt, 2 * 40 * 30);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[16];

    initial begin
        int done, n, m, da_cnt, hs_low, hs_first, le_cnt, le_h;
        logic found;
        obs_t rst_exp_s;

        rst_n   = 1'b0;
        rst_s_n = 1'b0;

        vecs[0]  = mk(0,    799, 524, 1, 1, 0, 0, 0, 0);
        vecs[1]  = mk(1,    0,   0,   1, 1, 1, 0, 0, 0);
        vecs[2]  = mk(64,   63,  0,   1, 1, 1, 0, 0, 0);
        vecs[3]  = mk(65,   64,  0,   1, 1, 1, 0, 0, 1);
        vecs[4]  = mk(577,  576, 0,   1, 1, 1, 0, 0, 9);
        vecs[5]  = mk(640,  639, 0,   1, 1, 1, 1, 0, 9);
        vecs[6]  = mk(641,  640, 0,   1, 1, 0, 0, 0, 0);
        vecs[7]  = mk(656,  655, 0,   1, 1, 0, 0, 0, 0);
        vecs[8]  = mk(657,  656, 0,   0, 1, 0, 0, 0, 0);
        vecs[9]  = mk(701,  700, 0,   0, 1, 0, 0, 0, 0);
        vecs[10] = mk(752,  751, 0,   0, 1, 0, 0, 0, 0);
        vecs[11] = mk(753,  752, 0,   1, 1, 0, 0, 0, 0);
        vecs[12] = mk(800,  799, 0,   1, 1, 0, 0, 0, 0);
        vecs[13] = mk(801,  0,   1,   1, 1, 1, 0, 0, 0);
        vecs[14] = mk(1440, 639, 1,   1, 1, 1, 1, 0, 9);
        vecs[15] = mk(1441, 640, 1,   1, 1, 0, 0, 0, 0);

        // Full-size instance: reset then table of fixed points along the first lines.
        repeat (3) tick_def(1'b0);
        done = 0;
        foreach (vecs[i]) begin
            while (done < vecs[i].steps) begin
                tick_def(1'b1);
                done++;
            end
            check_obs($sformatf("vec_step_%0d", vecs[i].steps), sample_def(), vecs[i].e);
        end

        // One complete line from a fresh reset.
        repeat (2) tick_def(1'b0);
        da_cnt = 0; hs_low = 0; hs_first = -1; le_cnt = 0; le_h = -1;
        repeat (800) begin
            tick_def(1'b1);
            check_obs("line_model", sample_def(), model(t_def, pos_def));
            if (disp_active) da_cnt++;
            if (!hsync) begin
                if (hs_first < 0) hs_first = int'(h_count);
                hs_low++;
            end
            if (line_end) begin
                le_cnt++;
                le_h = int'(h_count);
            end
        end
        check_int("line_disp_clocks", da_cnt, 640);
        check_int("line_hsync_low_clocks", hs_low, 96);
        check_int("line_hsync_first_h", hs_first, 656);
        check_int("line_line_end_count", le_cnt, 1);
        check_int("line_line_end_h", le_h, 639);
        tick_def(1'b1);
        check_int("line_period_h", int'(h_count), 0);
        check_int("line_period_v", int'(v_count), 1);

        // Random run lengths interleaved with random-length resets.
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(50, 2500);
            repeat (n) begin
                tick_def(1'b1);
                check_obs("rand_run", sample_def(), model(t_def, pos_def));
            end
            m = $urandom_range(1, 4);
            repeat (m) begin
                tick_def(1'b0);
                check_obs("rand_reset", sample_def(), model(t_def, pos_def));
            end
        end
        tick_def(1'b1);
        check_obs("rand_release", sample_def(), model(t_def, pos_def));

        // Reduced-size instance: full frames, wrap corner, mid-frame reset.
        rst_exp_s = '{h: 10'd55, v: 10'd39, hs: 1'b1, vs: 1'b1, da: 1'b0, le: 1'b0, fe: 1'b0, tp: 4'd0};
        repeat (3) tick_s(1'b0);
        check_obs("small_reset", sample_s(), rst_exp_s);
        run_frames_s("frames");

        check_obs("wrap_pre", sample_s(), rst_exp_s);
        tick_s(1'b1);
        check_obs("wrap_post", sample_s(),
                  '{h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, da: 1'b1, le: 1'b0, fe: 1'b0, tp: 4'd0});

        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (h_count_s == 10'd30 && v_count_s == 10'd20) found = 1'b1;
            else tick_s(1'b1);
        end
        check_int("midreset_reached", int'(found), 1);
        for (int i = 0; i < 3; i++) begin
            tick_s(1'b0);
            check_obs($sformatf("midreset_hold_%0d", i), sample_s(), rst_exp_s);
        end
        run_frames_s("restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock.
- Drives hsync/vsync to the connector.
- Supplies disp_active, line_end and frame_end to the downstream pixel feeder, which uses them to step its /10 scaling counters and its row-buffer fetches.
- Exports raw h/v pixel coordinates for other consumers (overlay, debug).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk_25  in  1  pixel clock, 25 MHz
- rst_n  in  1  synchronous active-low reset
- hsync  out  1  horizontal sync, SYNC_POL asserted
- vsync  out  1  vertical sync, SYNC_POL asserted
- disp_active  out  1  high when the current pixel is visible
- line_end  out  1  one-clock pulse on the last visible pixel of each visible line
- frame_end  out  1  one-clock pulse on the last visible pixel of the frame
- h_count  out  10  current horizontal position, 0..H_TOTAL-1
- v_count  out  10  current line, 0..V_TOTAL-1

Behaviour:
- Reset and clock are decided: reset rst_n, synchronous, active-low; clock clk_25.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Every output is a flop or a decode of flops only. No combinational path from inputs.
- All outputs describe the same pixel (h_count, v_count) in the same cycle.

Reset values:
- h_count = H_TOTAL-1 (799), v_count = V_TOTAL-1 (524).
- Both FSMs in PH_BACK.
- disp_active = 0, line_end = 0, frame_end = 0, hsync = vsync = !SYNC_POL.
- The first edge after rst_n rises moves to (0,0) with disp_active = 1.

Reset mid-frame:
- Any cycle with rst_n low reloads the reset values on that edge.
- No partial pulse is emitted.
- The raster restarts cleanly as above.

Horizontal FSM:
- States PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK, with a segment counter.
- h_count increments every clock and wraps 799 -> 0.
- Transitions occur when h_count reaches 639 / 655 / 751 / 799 (ACTIVE->FRONT->SYNC->BACK->ACTIVE).

Vertical FSM:
- Same four states.
- Advances only on the h wrap cycle (h_count == 799).
- v_count wraps 524 -> 0; transitions at 479 / 489 / 491 / 524.

Decodes:
- hsync asserted iff h_count in 656..751.
- vsync asserted iff v_count in 490..491. vsync changes aligned to the h wrap edge.
- disp_active = (h_count < 640) && (v_count < 480).
- line_end = (h_count == 639) && (v_count < 480). Exactly 480 pulses per frame.
- frame_end = (h_count == 639) && (v_count == 479). Coincides with the final line_end.
- Simultaneous h wrap and v wrap (h=799, v=524) advances to (0,0) in one edge.
- Counter arithmetic is 10-bit unsigned; compare-and-reload only, never relies on overflow.

Optional Feature:
- Macro: VGA_TESTPAT_EN.
- With the macro: adds port test_pix (out, 4 bits).
  - test_pix = h_count[9:6] when disp_active, else 0, registered alongside the counters.
  - Result is 10 vertical bars, values 0..9.
- Without the macro: port and logic are absent; all other behaviour is unchanged.

Decomposition:
- Shared package vga_pkg:
  - typedef enum vga_phase_t {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK};
  - default 640x480 timing localparams;
  - function computing the segment end-counts from active/fp/sync/bp.
- Sub-module vga_axis_counter, instantiated twice (H with advance tied high, V with advance = H wrap).
  - Parameters: active/fp/sync/bp.
  - Inputs: clk_25, rst_n, advance.
  - Outputs: count, phase, wrap, sync.

Test Plan:
- Reset then release: during reset h=799, v=524, disp_active=0, hsync=vsync=1; first edge after release -> h=0, v=0, disp_active=1.
- Run one line: disp_active high 640 clocks; hsync low exactly at h=656..751 (96 clocks); line period 800 clocks; line_end high only at h=639.
- Run full frame: 480 line_end pulses, 1 frame_end at (639,479) coincident with the last line_end; vsync low for 1600 clocks starting at (0,490); frame period 420000 clocks.
- Wrap corner: at (799,524) the next edge gives (0,0) with disp_active=1; no spurious line_end or frame_end.
- Mid-frame reset: assert rst_n low for 3 clocks at (300,200) -> outputs at reset values; after release the frame restarts at (0,0) and timing matches the full-frame check.
- With VGA_TESTPAT_EN: test_pix = 0 at h=0..63, 9 at h=576..639, 0 during blanking (h=700).
